mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-to-1 data mux between four requesters and presents the selected word to a single downstream consumer over a valid/ready handshake. It owns the mux select, holds it stable for the duration of each transfer, and rotates priority so that no requester starves. It sits between four producer ports and the shared output path, and replaces hand-driven `s0`/`s1` select lines.

---
 rtl/mux4_arb_pkg.sv | 24 ++
 rtl/mux4_to_1.sv | 24 ++
 rtl/rr_pick4.sv | 36 +++
 rtl/mux4_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types and helpers for the 4-way round-robin arbiter.
//   NUM_REQ     : number of requesters sharing the output path
//   idx_t       : 2-bit requester index
//   arb_state_e : arbiter FSM states
//   onehot()    : index -> one-hot grant vector
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_to_1.sv
// mux4_to_1: single-bit 4-to-1 mux cell.
//   d0..d3 : data inputs
//   s0, s1 : select, {s1,s0} is the binary index of the chosen input
//   y      : selected data
module mux4_to_1 (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic s0,
  input  logic s1,
  output logic y
);

  always_comb begin
    unique case ({s1, s0})
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: combinational rotating-priority pick over four requests.
//   req   : request vector
//   ptr   : index with highest priority; priority falls upward mod 4
//   found : at least one request set
//   idx   : first set bit at or after ptr
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               ptr,
  output logic               found,
  output idx_t               idx
);

  idx_t cand [NUM_REQ];

  // Candidate k is the k-th slot after ptr; the 2-bit add wraps 3->0.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      cand[k] = ptr + idx_t'(k);
    end
  end

  // Scan from the farthest slot down so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter owning the select of a shared 4-to-1
// data mux, presenting the chosen word over a valid/ready handshake.
//   clk, rst_n         : clock, synchronous active-low reset
//   req[3:0]           : per-requester request
//   in0..in3 [W-1:0]   : requester data, held stable until acked
//   out_ready          : consumer accepts this cycle
//   lock               : keep the grant after this beat (MUX4_ARB_LOCK_EN)
//   gnt[3:0]           : one-hot grant, zero when idle
//   sel[1:0]           : binary grant index, drives the mux select
//   out_valid          : out_data is valid
//   out_data [W-1:0]   : in[sel]
//   ack[3:0]           : one-cycle handshake pulse to the served requester
// Optional feature macro: MUX4_ARB_LOCK_EN adds the lock port (burst grant).
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       in0,
  input  logic [W-1:0]       in1,
  input  logic [W-1:0]       in2,
  input  logic [W-1:0]       in3,
  input  logic               out_ready,
`ifdef MUX4_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output idx_t               sel,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [NUM_REQ-1:0] ack
);

`ifndef MUX4_ARB_LOCK_EN
  // Without the feature every handshake releases the grant.
  logic lock;
  assign lock = 1'b0;
`endif

  arb_state_e         state_q, state_d;
  idx_t               g_q, g_d;
  idx_t               ptr_q, ptr_d;

  logic               hs;
  logic [NUM_REQ-1:0] pick_req;
  idx_t               pick_ptr;
  logic               pick_found;
  idx_t               pick_idx;

  // Outputs are pure decodes of registered state, so sel/gnt/out_data
  // cannot move while the consumer stalls.
  assign out_valid = (state_q == ARB_BUSY);
  assign gnt       = out_valid ? onehot(g_q) : '0;
  assign sel       = g_q;
  assign hs        = out_valid & out_ready;
  assign ack       = gnt & {NUM_REQ{hs}};

  // One picker serves both states. In BUSY it only matters on a handshake,
  // where the pointer it sees is the already-advanced one and the
  // just-served requester is masked out for this cycle.
  always_comb begin
    pick_req = req;
    pick_ptr = ptr_q;
    if (state_q == ARB_BUSY) begin
      pick_req = req & ~gnt;
      pick_ptr = g_q + 2'd1;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          g_d     = pick_idx;
        end
      end
      ARB_BUSY: begin
        // No handshake: the transfer is committed, req changes ignored.
        if (hs && !lock) begin
          ptr_d = g_q + 2'd1;
          if (pick_found) begin
            g_d = pick_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
    end
  end

  // Shared data path: one mux cell per output bit.
  for (genvar b = 0; b < W; b++) begin : g_mux
    mux4_to_1 u_mux (
      .d0 (in0[b]),
      .d1 (in1[b]),
      .d2 (in2[b]),
      .d3 (in3[b]),
      .s0 (sel[0]),
      .s1 (sel[1]),
      .y  (out_data[b])
    );
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scoreboard bench for mux4_rr_arbiter.
// Stimulus pushes expected {ack, data} per handshake; the monitor pops on
// every observed handshake. Honors MUX4_ARB_LOCK_EN for the lock scenario.
module tb_mux4_rr_arbiter;
  localparam int W = 8;

  typedef struct packed {
    logic [3:0]   ack;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] in0, in1, in2, in3;
  logic         out_ready;
  logic         lock;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   ack;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
`ifdef MUX4_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack       (ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [W-1:0] d);
    exp_t e;
    e.ack  = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_handshake", {28'd0, ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack", {28'd0, ack}, {28'd0, e.ack});
        chk("sb_data", {24'd0, out_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b0; lock = 1'b0;
    in0 = 8'hA0; in1 = 8'hA1; in2 = 8'hA2; in3 = 8'hA3;

    // Reset held with all requests pending.
    repeat (3) step();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_gnt", {28'd0, gnt}, 32'h1);
    chk("rel_sel", {30'd0, sel}, 32'd0);
    chk("rel_valid", {31'd0, out_valid}, 32'd1);

    // Round robin with everybody requesting.
    push(4'b0001, 8'hA0); push(4'b0010, 8'hA1); push(4'b0100, 8'hA2);
    push(4'b1000, 8'hA3); push(4'b0001, 8'hA0);
    out_ready = 1'b1;
    repeat (5) step();

    // Finish requester 1, leaving only requester 2 so it gets the grant.
    chk("rr_sel1", {30'd0, sel}, 32'd1);
    push(4'b0010, 8'hA1);
    req = 4'b0100;
    step();
    out_ready = 1'b0;

    // Backpressure on requester 2.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sel", {30'd0, sel}, 32'd2);
      chk("bp_data", {24'd0, out_data}, 32'hA2);
      chk("bp_gnt", {28'd0, gnt}, 32'h4);
      chk("bp_ack", {28'd0, ack}, 32'd0);
    end
    push(4'b0100, 8'hA2);
    out_ready = 1'b1;
    step();
    chk("bp_ack_once", {28'd0, ack}, 32'd0);
    chk("bp_idle", {31'd0, out_valid}, 32'd0);

    // Wrap: ptr is 3, requester 3 must win over 0.
    push(4'b1000, 8'hA3); push(4'b0001, 8'hA0);
    req = 4'b1001;
    step();
    chk("wrap_sel", {30'd0, sel}, 32'd3);
    req = 4'b0001;
    step();
    chk("wrap_sel0", {30'd0, sel}, 32'd0);
    req = 4'b0000;
    step();
    chk("wrap_idle", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a stalled transfer.
    req = 4'b0010; out_ready = 1'b0;
    step();
    chk("mid_sel", {30'd0, sel}, 32'd1);
    rst_n = 1'b0; req = 4'b1111;
    step();
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_ack", {28'd0, ack}, 32'd0);
    chk("mid_gnt", {28'd0, gnt}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid_restart", {28'd0, gnt}, 32'h1);
    push(4'b0001, 8'hA0);
    req = 4'b0001; out_ready = 1'b1;
    step();
    req = 4'b0000; out_ready = 1'b0;

`ifdef MUX4_ARB_LOCK_EN
    // Burst: ptr is 1; lock kept over two beats, released on the third.
    req = 4'b1111;
    step();
    chk("lock_sel", {30'd0, sel}, 32'd1);
    push(4'b0010, 8'hA1); push(4'b0010, 8'hA1); push(4'b0010, 8'hA1);
    push(4'b0100, 8'hA2);
    out_ready = 1'b1; lock = 1'b1;
    step();
    step();
    lock = 1'b0; req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    out_ready = 1'b0;
`endif

    repeat (3) step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
